// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks a low column across the matrix, debounces
// whole-scan results and reports a single pressed key as {row_idx, col_idx}.
//
// state | meaning
// IDLE  | no debounced key held; key_down low
// HELD  | debounced key held; key_code holds it, key_down high
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [1:0]    hit_cnt;
  logic [3:0]    hit_code;
  logic          multi;
  res_t          prev_res;
  logic [3:0]    prev_code;
  logic [SW-1:0] stable_cnt;
  state_t        state;

  logic       tc, scan_end, one_low, samp_hit, samp_multi, same, fire;
  logic [3:0] rows_low;
  logic [1:0] row_idx;
  res_t       res_kind;
  logic [3:0] res_code;

  assign tc       = (dwell == DW'(SCAN_DIV - 1));
  assign scan_end = tc && (col_idx == 2'd3);
  assign rows_low = ~row_s2;
  assign one_low  = (rows_low != 4'b0) && ((rows_low & (rows_low - 4'd1)) == 4'b0);
  assign samp_hit   = tc && one_low;
  assign samp_multi = tc && (rows_low != 4'b0) && !one_low;

  always_comb begin
    row_idx = 2'd0;
    case (rows_low)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // The col 3 sample has not reached the accumulator yet, so fold it in here.
  always_comb begin
    res_kind = RES_NONE;
    res_code = 4'd0;
    if (multi || samp_multi) begin
      res_kind = RES_MULTI;
    end else if (hit_cnt == 2'd0 && samp_hit) begin
      res_kind = RES_KEY;
      res_code = {row_idx, col_idx};
    end else if (hit_cnt == 2'd1 && !samp_hit) begin
      res_kind = RES_KEY;
      res_code = hit_code;
    end else if (hit_cnt != 2'd0) begin
      res_kind = RES_MULTI;
    end
  end

  assign same = (res_kind == prev_res) && ((res_kind != RES_KEY) || (res_code == prev_code));
  assign fire = scan_end && (same ? (stable_cnt == SW'(DEBOUNCE_SCANS - 1))
                                  : (DEBOUNCE_SCANS == 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1     <= 4'b1111;
      row_s2     <= 4'b1111;
      dwell      <= '0;
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      hit_cnt    <= 2'd0;
      hit_code   <= 4'd0;
      multi      <= 1'b0;
      prev_res   <= RES_NONE;
      prev_code  <= 4'd0;
      stable_cnt <= '0;
      state      <= IDLE;
      key_code   <= 4'd0;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      key_valid <= 1'b0;
      if (tc) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= ~(4'b0001 << (col_idx + 2'd1));
        if (scan_end) begin
          hit_cnt  <= 2'd0;
          hit_code <= 4'd0;
          multi    <= 1'b0;
          if (same) begin
            if (stable_cnt != SW'(DEBOUNCE_SCANS))
              stable_cnt <= stable_cnt + SW'(1);
          end else begin
            prev_res   <= res_kind;
            prev_code  <= res_code;
            stable_cnt <= SW'(1);
          end
          if (fire) begin
            case (state)
              IDLE: if (res_kind == RES_KEY) begin
                state     <= HELD;
                key_code  <= res_code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end
              HELD: if (res_kind == RES_KEY && res_code != key_code) begin
                key_code  <= res_code;
                key_valid <= 1'b1;
              end else if (res_kind == RES_NONE) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end
              default: state <= IDLE;
            endcase
          end
        end else begin
          if (samp_multi) multi <= 1'b1;
          if (samp_hit) begin
            if (hit_cnt == 2'd0) hit_code <= {row_idx, col_idx};
            if (hit_cnt != 2'd2) hit_cnt <= hit_cnt + 2'd1;
          end
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=8, DEBOUNCE_SCANS=2 (32-cycle scan).
// Times below are "after posedge N" counted from the first edge out of reset.
module tb_keypad_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_down;
  logic [15:0] keys = '0;   // bit index r*4+c equals the key code
  int          n_checks = 0;
  int          n_fail = 0;
  int          pulses = 0;
  int          base;
  logic        kv_prev = 1'b0;

  keypad_scan #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low through any closed key on a driven column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  always @(posedge clk) begin
    if (key_valid) begin
      pulses++;
      n_checks++;
      if (kv_prev) begin
        n_fail++;
        $display("FAIL valid_consecutive: key_valid high two cycles in a row at %0t", $time);
      end
    end
    kv_prev = key_valid;
  end

  task automatic reset_dut();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    keys = '0;
    reset_dut();
    n_checks++;
    if (col !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: col=%b code=%h valid=%b down=%b, want 1110 0 0 0",
               col, key_code, key_valid, key_down);
    end
    for (int i = 0; i < 4; i++) begin
      wait_cycles(8);
      n_checks++;
      if (col !== exp_col[i]) begin
        n_fail++;
        $display("FAIL col_step%0d: col=%b, want %b", i, col, exp_col[i]);
      end
    end
  endtask

  task automatic test_single_press();
    reset_dut();
    keys = 16'h0200;
    base = pulses;
    wait_cycles(63);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL press_early: key_valid=%b at 63, want 0", key_valid);
    end
    wait_cycles(1);
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9 || key_down !== 1'b1) begin
      n_fail++;
      $display("FAIL press_report: valid=%b code=%h down=%b, want 1 9 1", key_valid, key_code, key_down);
    end
    wait_cycles(1);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL press_pulse_width: key_valid=%b at 65, want 0", key_valid);
    end
    wait_cycles(160);
    n_checks++;
    if (pulses - base !== 1 || key_down !== 1'b1) begin
      n_fail++;
      $display("FAIL press_hold: pulses=%0d down=%b, want 1 1", pulses - base, key_down);
    end
  endtask

  task automatic test_bounce();
    keys = '0;
    reset_dut();
    base = pulses;
    for (int i = 0; i < 9; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      wait_cycles(11);
    end
    keys = 16'h0200;
    n_checks++;
    if (pulses - base !== 0 || key_down !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_window: pulses=%0d down=%b, want 0 0", pulses - base, key_down);
    end
    wait_cycles(101);
    n_checks++;
    if (pulses - base !== 1 || key_code !== 4'h9 || key_down !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_settle: pulses=%0d code=%h down=%b, want 1 9 1",
               pulses - base, key_code, key_down);
    end
  endtask

  // Continues from the bounce test: HELD with code 9, now at 200.
  task automatic test_release_rollover();
    keys = '0;
    base = pulses;
    wait_cycles(55);
    n_checks++;
    if (key_down !== 1'b1) begin
      n_fail++; $display("FAIL release_early: key_down=%b at 255, want 1", key_down);
    end
    wait_cycles(1);
    n_checks++;
    if (key_down !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h9 || pulses - base !== 0) begin
      n_fail++;
      $display("FAIL release: down=%b valid=%b code=%h pulses=%0d, want 0 0 9 0",
               key_down, key_valid, key_code, pulses - base);
    end
    keys = 16'h0200;
    wait_cycles(64);
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9 || key_down !== 1'b1) begin
      n_fail++;
      $display("FAIL repress: valid=%b code=%h down=%b, want 1 9 1", key_valid, key_code, key_down);
    end
    keys = 16'h0008;
    wait_cycles(63);
    n_checks++;
    if (key_valid !== 1'b0 || key_code !== 4'h9) begin
      n_fail++;
      $display("FAIL rollover_early: valid=%b code=%h at 383, want 0 9", key_valid, key_code);
    end
    wait_cycles(1);
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h3 || key_down !== 1'b1) begin
      n_fail++;
      $display("FAIL rollover: valid=%b code=%h down=%b, want 1 3 1", key_valid, key_code, key_down);
    end
  endtask

  task automatic test_ghost();
    keys = 16'h4001;
    reset_dut();
    base = pulses;
    wait_cycles(128);
    n_checks++;
    if (pulses - base !== 0 || key_down !== 1'b0 || key_code !== 4'h0) begin
      n_fail++;
      $display("FAIL ghost_idle: pulses=%0d down=%b code=%h, want 0 0 0",
               pulses - base, key_down, key_code);
    end
    keys = 16'h4000;
    wait_cycles(63);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL ghost_release_early: key_valid=%b at 191, want 0", key_valid);
    end
    wait_cycles(1);
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'hE || key_down !== 1'b1) begin
      n_fail++;
      $display("FAIL ghost_release: valid=%b code=%h down=%b, want 1 e 1", key_valid, key_code, key_down);
    end
    wait_cycles(1);
    base = pulses;
    keys = 16'h4004;   // two rows low on col 2 while HELD
    wait_cycles(127);
    n_checks++;
    if (pulses - base !== 0 || key_down !== 1'b1 || key_code !== 4'hE) begin
      n_fail++;
      $display("FAIL ghost_held: pulses=%0d down=%b code=%h, want 0 1 e",
               pulses - base, key_down, key_code);
    end
  endtask

  task automatic test_reset_mid_debounce();
    keys = 16'h0200;
    reset_dut();
    base = pulses;
    wait_cycles(32);
    reset = 1'b1;
    wait_cycles(1);
    n_checks++;
    if (col !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: col=%b code=%h valid=%b down=%b, want 1110 0 0 0",
               col, key_code, key_valid, key_down);
    end
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(32);
    n_checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stale: valid=%b down=%b at 32, want 0 0", key_valid, key_down);
    end
    wait_cycles(32);
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9 || key_down !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_report: valid=%b code=%h down=%b at 64, want 1 9 1",
               key_valid, key_code, key_down);
    end
    wait_cycles(2);
    n_checks++;
    if (pulses - base !== 1) begin
      n_fail++; $display("FAIL midreset_pulses: pulses=%0d, want 1", pulses - base);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_release_rollover();
    test_ghost();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
